alarm_buzzer_ctrl: RTL and testbench

- Alarm stage directly downstream of the clock top-level.
- Consumes the running BCD time, the alarm setting and a 1 Hz tick. Detects the alarm instant and drives a gated square-wave buzzer with an on/off beep cadence.
- Supports stop, snooze and an auto-timeout.
- Outputs feed the board buzzer pin and a status LED.

---
 rtl/clock_pkg.sv | 19 +
 rtl/alarm_buzzer_ctrl_tone_gen.sv | 49 ++++
 rtl/alarm_buzzer_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alarm_buzzer_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/alarm blocks.
// Holds the alarm FSM state encoding and the BCD helpers.
package clock_pkg;

  localparam int BCD_W = 8;
  localparam logic [BCD_W-1:0] SEC_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  // Raw 8-bit equality; BCD digits are deliberately not validated.
  function automatic logic bcd_eq(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/alarm_buzzer_ctrl_tone_gen.sv
// Square-wave tone generator: toggles every TONE_DIV cycles while gate is open,
// otherwise holds the divider at 0 and forces the wave low on the next cycle.
module tone_gen #(
  parameter int TONE_DIV = 12500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic gate,
  output logic wave
);

  localparam int DIV_W = $clog2(TONE_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             wave_q, wave_d;

  // Divider advance and wave toggle at the wrap.
  always_comb begin
    div_d  = '0;
    wave_d = 1'b0;
    if (gate) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        wave_d = ~wave_q;
      end else begin
        div_d  = div_q + DIV_W'(1);
        wave_d = wave_q;
      end
    end else begin
      div_d  = '0;
      wave_d = 1'b0;
    end
  end

  // Divider and wave registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      div_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm detection, ring/snooze FSM, beep cadence and timeout for the buzzer pin.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_buzzer_ctrl
  import clock_pkg::*;
#(
  parameter int TONE_DIV         = 12500,
  parameter int BEEP_ON_CYC      = 10_000_000,
  parameter int BEEP_PERIOD_CYC  = 25_000_000,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int SNOOZE_SEC       = 300
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alarm_en,
  input  logic             sec_tick,
  input  logic [BCD_W-1:0] hour_time,
  input  logic [BCD_W-1:0] min_time,
  input  logic [BCD_W-1:0] sec_time,
  input  logic [BCD_W-1:0] hour_alarm,
  input  logic [BCD_W-1:0] min_alarm,
  input  logic             stop_key,
  input  logic             snooze_key,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozed,
  output logic             led_blink
);

  localparam int CAD_W = $clog2(BEEP_PERIOD_CYC) + 1;
  localparam logic [CAD_W-1:0] CAD_LAST = CAD_W'(BEEP_PERIOD_CYC - 1);
  localparam logic [CAD_W-1:0] CAD_ON   = CAD_W'(BEEP_ON_CYC);
  localparam int SEC_W = $clog2(RING_TIMEOUT_SEC) + 1;
  localparam logic [SEC_W-1:0] SEC_LIM  = SEC_W'(RING_TIMEOUT_SEC);

  alarm_state_t     state_q, state_d;
  logic             match, trig, gate;
  logic             match_q;
  logic [CAD_W-1:0] cad_q, cad_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d, sec_inc;
  logic             ringing_q, ringing_d;
  logic             led_blink_q, led_blink_d;

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_SEC) + 1;
  localparam logic [SNZ_W-1:0] SNZ_LIM = SNZ_W'(SNOOZE_SEC);

  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d, snz_inc;
  logic             snoozed_q, snoozed_d;
`else
  // Snooze length has no meaning in this build.
  logic             unused_snooze_cfg;
  assign unused_snooze_cfg = |SNOOZE_SEC;
`endif

  // Alarm instant detection and tone gate.
  always_comb begin
    match = bcd_eq(hour_time, hour_alarm) & bcd_eq(min_time, min_alarm) &
            bcd_eq(sec_time, SEC_ZERO);
    trig  = match & ~match_q & alarm_en;
    gate  = (state_q == RING) && (cad_q < CAD_ON);
  end

  // Next-state logic; counters are nonzero only while staying in their own state.
  always_comb begin
    state_d   = state_q;
    cad_d     = '0;
    sec_cnt_d = '0;
    sec_inc   = sec_cnt_q + SEC_W'(1);
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d = '0;
    snz_inc   = snz_cnt_q + SNZ_W'(1);
`endif
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = RING;
        end else begin
          state_d = IDLE;
        end
      end
      RING: begin
        if (!alarm_en || stop_key) begin
          state_d = IDLE;
        end else if (snooze_key) begin
`ifdef ALARM_SNOOZE_EN
          state_d = SNOOZE;
`else
          state_d = IDLE;
`endif
        end else if (sec_tick && (sec_inc == SEC_LIM)) begin
          state_d = IDLE;
        end else begin
          state_d   = RING;
          cad_d     = (cad_q == CAD_LAST) ? '0 : cad_q + CAD_W'(1);
          sec_cnt_d = sec_tick ? sec_inc : sec_cnt_q;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!alarm_en || stop_key) begin
          state_d = IDLE;
        end else if (trig) begin
          state_d = RING;
        end else if (sec_tick && (snz_inc == SNZ_LIM)) begin
          state_d = RING;
        end else begin
          state_d   = SNOOZE;
          snz_cnt_d = sec_tick ? snz_inc : snz_cnt_q;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered status outputs.
  always_comb begin
    ringing_d   = (state_d == RING);
    led_blink_d = gate;
`ifdef ALARM_SNOOZE_EN
    snoozed_d   = (state_d == SNOOZE);
`endif
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= IDLE;
      match_q     <= 1'b0;
      cad_q       <= '0;
      sec_cnt_q   <= '0;
      ringing_q   <= 1'b0;
      led_blink_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match;
      cad_q       <= cad_d;
      sec_cnt_q   <= sec_cnt_d;
      ringing_q   <= ringing_d;
      led_blink_q <= led_blink_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze counter and status register.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      snz_cnt_q <= '0;
      snoozed_q <= 1'b0;
    end else begin
      snz_cnt_q <= snz_cnt_d;
      snoozed_q <= snoozed_d;
    end
  end

  assign snoozed = snoozed_q;
`else
  assign snoozed = 1'b0;
`endif

  tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .gate    (gate),
    .wave    (buzzer)
  );

  assign ringing   = ringing_q;
  assign led_blink = led_blink_q;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Randomized scenario bench for alarm_buzzer_ctrl against a timeline model:
// ring sessions are tracked by age, and buzzer/LED are derived arithmetically from it.
module tb_alarm_buzzer_ctrl;

  localparam int TD      = 4;
  localparam int ON      = 8;
  localparam int PER     = 16;
  localparam int TMO     = 3;
  localparam int SNZ_SEC = 5;
  localparam int TICK    = 50;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_BUILD = 1'b1;
`else
  localparam bit SNZ_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, alarm_en, sec_tick, stop_key, snooze_key;
  logic [7:0] hour_time, min_time, sec_time, hour_alarm, min_alarm;
  logic       buzzer, ringing, snoozed, led_blink;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: whether ringing/snoozed, cycles since ring entry, seconds counted.
  bit m_ring = 1'b0, m_snz = 1'b0, m_prev_match = 1'b0;
  int m_age = 0, m_secs = 0, m_snzs = 0;

  always #5 clk = ~clk;

  alarm_buzzer_ctrl #(
    .TONE_DIV         (TD),
    .BEEP_ON_CYC      (ON),
    .BEEP_PERIOD_CYC  (PER),
    .RING_TIMEOUT_SEC (TMO),
    .SNOOZE_SEC       (SNZ_SEC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alarm_en   (alarm_en),
    .sec_tick   (sec_tick),
    .hour_time  (hour_time),
    .min_time   (min_time),
    .sec_time   (sec_time),
    .hour_alarm (hour_alarm),
    .min_alarm  (min_alarm),
    .stop_key   (stop_key),
    .snooze_key (snooze_key),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .led_blink  (led_blink)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // One clock: apply tick, advance model on the edge, compare 1 time unit later.
  task automatic step();
    logic mt, tg, r0, rst, go_ring, exp_buz, exp_led;
    int   a0, ph;
    sec_tick = ((cyc % TICK) == TICK - 1);
    @(posedge clk);
    rst = reset_n;
    mt  = (hour_time == hour_alarm) && (min_time == min_alarm) && (sec_time == 8'h00);
    tg  = mt && !m_prev_match && alarm_en;
    r0  = m_ring;
    a0  = m_age;
    ph  = (a0 + 1) % PER;
    exp_buz = !rst && r0 && (ph <= ON) && (((ph / TD) % 2) == 1);
    exp_led = !rst && r0 && ((a0 % PER) < ON);
    go_ring = 1'b0;
    if (rst) begin
      m_ring = 1'b0; m_snz = 1'b0; m_prev_match = 1'b0;
      m_age = 0; m_secs = 0; m_snzs = 0;
    end else begin
      if (m_ring) begin
        m_age++;
        if (!alarm_en || stop_key) begin
          m_ring = 1'b0;
        end else if (snooze_key) begin
          m_ring = 1'b0;
          m_snz  = SNZ_BUILD;
          m_snzs = 0;
        end else if (sec_tick) begin
          m_secs++;
          if (m_secs == TMO) m_ring = 1'b0;
        end
      end else if (m_snz) begin
        if (!alarm_en || stop_key) begin
          m_snz = 1'b0;
        end else if (tg) begin
          go_ring = 1'b1;
        end else if (sec_tick) begin
          m_snzs++;
          if (m_snzs == SNZ_SEC) go_ring = 1'b1;
        end
      end else if (tg) begin
        go_ring = 1'b1;
      end
      if (go_ring) begin
        m_ring = 1'b1; m_snz = 1'b0; m_age = 0; m_secs = 0;
      end
      m_prev_match = mt;
    end
    #1;
    check("ringing", ringing, m_ring);
    check("snoozed", snoozed, m_snz);
    check("buzzer", buzzer, exp_buz);
    check("led_blink", led_blink, exp_led);
    cyc++;
    stop_key   = 1'b0;
    snooze_key = 1'b0;
    reset_n    = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b1;
    alarm_en   = 1'b0;
    stop_key   = 1'b0;
    snooze_key = 1'b0;
    sec_tick   = 1'b0;
    hour_alarm = 8'h07;
    min_alarm  = 8'h30;
    hour_time  = 8'h07;
    min_time   = 8'h29;
    sec_time   = 8'h59;
    repeat (3) begin
      reset_n = 1'b1;
      step();
    end
    for (int s = 0; s < 40; s++) begin
      int kind, ev_at, hold;
      kind = (s < 7) ? s : int'($urandom_range(0, 6));
      if (s >= 7) begin
        hour_alarm = 8'($urandom);
        min_alarm  = 8'($urandom);
      end
      alarm_en  = (kind != 6);
      hour_time = hour_alarm;
      min_time  = min_alarm - 8'h01;
      sec_time  = 8'h59;
      hold = $urandom_range(3, 20);
      repeat (hold) step();
      min_time = min_alarm;
      sec_time = 8'h00;
      ev_at = $urandom_range(2, 120);
      for (int k = 0; k < 700; k++) begin
        if (k == ev_at) begin
          case (kind)
            1: stop_key = 1'b1;
            2: begin stop_key = 1'b1; snooze_key = 1'b1; end
            3: snooze_key = 1'b1;
            4: alarm_en = 1'b0;
            5: begin reset_n = 1'b1; sec_time = 8'h01; end
            default: ;
          endcase
        end else if (kind == 3 && $urandom_range(0, 199) == 0) begin
          snooze_key = 1'b1;
        end
        step();
      end
      sec_time = 8'h01;
      repeat (10) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
